// File: rtl/cordic_rr_sched_pkg.sv
// Shared definitions for the round-robin cosine CORDIC scheduler.
//   - sched_state_e    : 2-bit FSM state encoding (IDLE, ISSUE, RUN, RESP)
//   - FP32_QNAN        : quiet NaN returned when the core watchdog aborts a job
//   - CORE_BUSY_CYCLES : nominal number of busy cycles of the cosine core
package cordic_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  localparam logic [31:0] FP32_QNAN        = 32'h7FC0_0000;
  localparam int unsigned CORE_BUSY_CYCLES = 32'd8;

endpackage

// File: rtl/cordic_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// Picks the first asserted req_valid bit at or after rr_ptr+1 (wrapping
// modulo NUM_REQ), so the most recently served requester has lowest priority.
// Ports:
//   req_valid  in  NUM_REQ  request lines
//   rr_ptr     in  ID_W     index of the last granted requester
//   grant      out NUM_REQ  one-hot grant (all zero when nothing requests)
//   grant_id   out ID_W     index of the granted requester
//   grant_any  out 1        some requester is granted
module rr_arbiter
  import cordic_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] idx_s;
  logic            hit_s;

  // Scan requesters in priority order starting just after rr_ptr; first hit wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s        = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      hit_s        = ~grant_any & req_valid[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      grant_id     = hit_s ? idx_s : grant_id;
      grant_any    = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// cordic_rr_sched: shares one iterative cosine CORDIC core between NUM_REQ
// requesters. Operands arrive on per-requester valid/ready channels, a
// round-robin arbiter selects one, the core is sequenced start -> run -> done,
// and the result returns on one tagged valid/ready response channel. A RUN
// watchdog aborts a hung core job with a quiet NaN and a sticky error flag.
// Ports:
//   clock        in   system clock
//   aclr         in   synchronous active-high reset (also resets the core)
//   clk_en       in   global enable; low freezes all state and the core
//   req_valid    in   per-requester operand valid
//   req_ready    out  per-requester accept (one-hot or zero)
//   req_data     in   FP32 operands, requester i at [32i+31:32i]
//   rsp_valid    out  result valid
//   rsp_ready    in   result accept
//   rsp_data     out  FP32 cosine result, or quiet NaN on timeout
//   rsp_id       out  requester index that owns rsp_data
//   core_start   out  start pulse to core
//   core_clk_en  out  core clock enable
//   core_dataa   out  latched operand to core
//   core_result  in   core FP32 output
//   core_done    in   core done level
//   busy         out  scheduler not idle
//   timeout_err  out  sticky watchdog-abort flag, cleared only by aclr
module cordic_rr_sched
  import cordic_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 5
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clk_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  core_start,
  output logic                  core_clk_en,
  output logic [31:0]           core_dataa,
  input  logic [31:0]           core_result,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  sched_state_e        state_r;
  sched_state_e        state_nxt_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [CNT_W-1:0]    wd_r;
  logic                rsp_valid_r;
  logic [31:0]         rsp_data_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [31:0]         core_dataa_r;
  logic                timeout_err_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_id_s;
  logic                grant_any_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic                core_start_s;
  logic                core_clk_en_s;
  logic                accept_s;
  logic                done_ok_s;
  logic                abort_s;
  logic                release_s;
  logic [31:0]         op_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_op
    assign op_s[g] = req_data[32*g +: 32];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_id  (grant_id_s),
    .grant_any (grant_any_s)
  );

  // FSM state register; clk_en low holds the state, aclr overrides clk_en.
  always_ff @(posedge clock) begin
    if (aclr) begin
      state_r <= ST_IDLE;
    end else if (clk_en) begin
      state_r <= state_nxt_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state decode plus per-state handshake and core control strobes.
  always_comb begin
    state_nxt_s   = state_r;
    req_ready_s   = '0;
    core_start_s  = 1'b0;
    core_clk_en_s = 1'b0;
    accept_s      = 1'b0;
    done_ok_s     = 1'b0;
    abort_s       = 1'b0;
    release_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Grant implies valid, so a grant is a completed handshake.
        req_ready_s = grant_s;
        if (grant_any_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // core_done may still show the previous job here; it is not looked at.
        core_start_s  = 1'b1;
        core_clk_en_s = 1'b1;
        state_nxt_s   = ST_RUN;
      end
      ST_RUN: begin
        // Drop the core enable in the done cycle so the core stops rotating.
        core_clk_en_s = ~core_done;
        if (core_done) begin
          done_ok_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (wd_r == TIMEOUT_CNT) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand/tag latches, watchdog, response register and sticky error flag.
  always_ff @(posedge clock) begin
    if (aclr) begin
      rr_ptr_r      <= ID_W'(NUM_REQ - 1);
      wd_r          <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 32'h0000_0000;
      rsp_id_r      <= '0;
      core_dataa_r  <= 32'h0000_0000;
      timeout_err_r <= 1'b0;
    end else if (clk_en) begin
      if (accept_s) begin
        core_dataa_r <= op_s[grant_id_s];
        rsp_id_r     <= grant_id_s;
        rr_ptr_r     <= grant_id_s;
      end
      if (state_r == ST_ISSUE) begin
        wd_r <= '0;
      end else if ((state_r == ST_RUN) && !done_ok_s && !abort_s) begin
        wd_r <= wd_r + CNT_W'(1);
      end
      if (done_ok_s) begin
        rsp_data_r  <= core_result;
        rsp_valid_r <= 1'b1;
      end else if (abort_s) begin
        rsp_data_r    <= FP32_QNAN;
        rsp_valid_r   <= 1'b1;
        timeout_err_r <= 1'b1;
      end else if (release_s) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready   = clk_en ? req_ready_s : '0;
  assign core_start  = clk_en & core_start_s;
  assign core_clk_en = clk_en & core_clk_en_s;
  assign core_dataa  = core_dataa_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_id      = rsp_id_r;
  assign busy        = (state_r != ST_IDLE);
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Self-checking bench for cordic_rr_sched with a behavioural cosine core
// model (table lookup after CORE_BUSY_CYCLES enabled cycles). Expected
// responses are queued when a request handshake is driven and compared when
// the response handshake occurs.
module tb_cordic_rr_sched;
  import cordic_rr_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clock;
  logic                  aclr;
  logic                  clk_en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  core_start;
  logic                  core_clk_en;
  logic [31:0]           core_dataa;
  logic [31:0]           core_result;
  logic                  core_done;
  logic                  busy;
  logic                  timeout_err;

  cordic_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(31), .CNT_W(5)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .core_start(core_start), .core_clk_en(core_clk_en), .core_dataa(core_dataa),
    .core_result(core_result), .core_done(core_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cosine of the operands used by this bench, FP32.
  function automatic logic [31:0] cos_lut(input logic [31:0] op);
    case (op)
      32'h0000_0000: cos_lut = 32'h3F80_0000; // cos(0.0)  = 1.0
      32'h3F00_0000: cos_lut = 32'h3F60_A940; // cos(0.5)
      32'h3F80_0000: cos_lut = 32'h3F0A_5140; // cos(1.0)
      32'h3FC0_0000: cos_lut = 32'h3D90_DEAA; // cos(1.5)
      32'h3F49_0FDB: cos_lut = 32'h3F35_04F3; // cos(pi/4)
      default:       cos_lut = 32'h0BAD_0BAD;
    endcase
  endfunction

  // Core model: busy for CORE_BUSY_CYCLES enabled cycles, then done level.
  logic        hang;
  int          core_cnt;
  logic        core_done_r;
  logic [31:0] core_op_r;
  always @(posedge clock) begin
    if (aclr) begin
      core_cnt    <= 0;
      core_done_r <= 1'b0;
      core_op_r   <= 32'h0;
    end else if (core_clk_en) begin
      if (core_start) begin
        core_op_r   <= core_dataa;
        core_cnt    <= CORE_BUSY_CYCLES;
        core_done_r <= 1'b0;
      end else if (core_cnt != 0) begin
        core_cnt    <= core_cnt - 1;
        core_done_r <= (core_cnt == 1) && !hang;
      end
    end
  end
  assign core_done   = core_done_r;
  assign core_result = core_done_r ? cos_lut(core_op_r) : 32'hDEAD_BEEF;

  int                  tests_run;
  int                  tests_failed;
  int                  cyc;
  int                  acc_cyc;
  int                  exp_lat;
  logic                rsp_seen;
  int                  jobs_left [NUM_REQ];
  logic [ID_W+31:0]    sb_q [$];
  int                  grant_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: sample handshakes after inputs settle, then advance.
  task automatic step();
    logic [NUM_REQ-1:0] drop;
    logic [ID_W+31:0]   e;
    #1;
    drop = '0;
    if (!aclr && clk_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back({ID_W'(i), hang ? FP32_QNAN : cos_lut(req_data[32*i +: 32])});
          grant_q.push_back(i);
          acc_cyc = cyc;
          if (jobs_left[i] > 0) jobs_left[i]--;
          if (jobs_left[i] == 0) drop[i] = 1'b1;
        end
      end
      if (core_start) check_eq("start_lat", 32'(cyc), 32'(acc_cyc + 1));
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1'b1;
        if (exp_lat != 0) check_eq("rsp_lat", 32'(cyc - acc_cyc), 32'(exp_lat));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("rsp_id", 32'(rsp_id), 32'(e[ID_W+31:32]));
          check_eq("rsp_data", rsp_data, e[31:0]);
        end
        rsp_seen = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    req_valid = req_valid & ~drop;
    cyc++;
    @(negedge clock);
  endtask

  task automatic launch(input int i, input logic [31:0] op, input int n);
    req_data[32*i +: 32] = op;
    jobs_left[i] = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (b > 0 && (sb_q.size() != 0 || req_valid != '0 || busy)) begin
      step();
      b--;
    end
    check_eq("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_grant(input int budget);
    int n0;
    int b;
    n0 = grant_q.size();
    b = budget;
    while (b > 0 && grant_q.size() == n0) begin
      step();
      b--;
    end
    check_eq("grant_seen", 32'(grant_q.size() - n0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_grants [5];
    int b;
    exp_grants = '{0, 1, 2, 3, 0};
    tests_run = 0; tests_failed = 0; cyc = 0; acc_cyc = 0; exp_lat = 11;
    rsp_seen = 1'b0; hang = 1'b0;
    aclr = 1'b1; clk_en = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) jobs_left[i] = 0;
    @(negedge clock);
    step(); step();

    // Reset values
    check_eq("rst_busy",        32'(busy),        32'd0);
    check_eq("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check_eq("rst_rsp_data",    rsp_data,         32'd0);
    check_eq("rst_rsp_id",      32'(rsp_id),      32'd0);
    check_eq("rst_req_ready",   32'(req_ready),   32'd0);
    check_eq("rst_core_start",  32'(core_start),  32'd0);
    check_eq("rst_core_clk_en", 32'(core_clk_en), 32'd0);
    check_eq("rst_core_dataa",  core_dataa,       32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    aclr = 1'b0;
    step();

    // Single job, requester 0, cos(0.0)
    launch(0, 32'h0000_0000, 1);
    drain(60);

    // Value check, requester 2, cos(pi/4)
    launch(2, 32'h3F49_0FDB, 1);
    drain(60);

    // Round-robin from reset: all four requesters, requester 0 wants two jobs
    aclr = 1'b1; step(); aclr = 1'b0; step();
    grant_q.delete();
    launch(0, 32'h0000_0000, 2);
    launch(1, 32'h3F00_0000, 1);
    launch(2, 32'h3F80_0000, 1);
    launch(3, 32'h3FC0_0000, 1);
    drain(200);
    check_eq("rr_count", 32'(grant_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check_eq("rr_order", (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFF_FFFF, 32'(exp_grants[i]));

    // Backpressure: hold rsp_ready low for 20 cycles with another requester waiting
    rsp_ready = 1'b0;
    launch(1, 32'h3F00_0000, 1);
    launch(3, 32'h3FC0_0000, 1);
    b = 40;
    while (b > 0 && !rsp_valid) begin step(); b--; end
    check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 20; k++) begin
      check_eq("bp_rsp_id",      32'(rsp_id),      32'd1);
      check_eq("bp_rsp_data",    rsp_data,         cos_lut(32'h3F00_0000));
      check_eq("bp_req_ready",   32'(req_ready),   32'd0);
      check_eq("bp_core_clk_en", 32'(core_clk_en), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_release", 32'(rsp_valid), 32'd0);
    drain(60);

    // Freeze for 5 cycles mid-RUN: response is 5 cycles later
    launch(0, 32'h3F80_0000, 1);
    wait_grant(20);
    for (int k = 0; k < 4; k++) step();
    clk_en = 1'b0;
    exp_lat = 16;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("frz_core_clk_en", 32'(core_clk_en), 32'd0);
      check_eq("frz_rsp_valid",   32'(rsp_valid),   32'd0);
    end
    clk_en = 1'b1;
    drain(60);
    exp_lat = 11;

    // Watchdog timeout: core never signals done
    check_eq("pre_timeout_err", 32'(timeout_err), 32'd0);
    hang = 1'b1;
    exp_lat = 0;
    launch(3, 32'h3FC0_0000, 1);
    drain(100);
    check_eq("to_err_set", 32'(timeout_err), 32'd1);
    hang = 1'b0;
    exp_lat = 11;
    launch(1, 32'h3F00_0000, 1);
    drain(60);
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);

    // aclr mid-RUN (together with clk_en low): job discarded, no response
    launch(2, 32'h3F80_0000, 1);
    wait_grant(20);
    for (int k = 0; k < 4; k++) step();
    aclr = 1'b1;
    clk_en = 1'b0;
    sb_q.delete();
    rsp_seen = 1'b0;
    step();
    check_eq("aclr_busy",        32'(busy),        32'd0);
    check_eq("aclr_rsp_valid",   32'(rsp_valid),   32'd0);
    check_eq("aclr_timeout_err", 32'(timeout_err), 32'd0);
    aclr = 1'b0;
    clk_en = 1'b1;
    for (int k = 0; k < 20; k++) step();
    check_eq("post_aclr_busy",      32'(busy),      32'd0);
    check_eq("post_aclr_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
